// File: rtl/alu.sv
// Mic-1 datapath ALU: combinational result and N/Z status, plus N/Z flags
// registered for the microsequencer's JAMN/JAMZ branches.
module alu #(
    parameter int NBITS       = 32,
    parameter int ALU_CONTROL = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NBITS-1:0]       a,
    input  logic [NBITS-1:0]       b,
    input  logic [ALU_CONTROL-1:0] ctrl,
    output logic [NBITS-1:0]       y,
    output logic                   n,
    output logic                   z,
    output logic                   n_q,
    output logic                   z_q
);

    typedef enum logic [1:0] {
        FN_AND  = 2'b00,
        FN_OR   = 2'b01,
        FN_NOTB = 2'b10,
        FN_ADD  = 2'b11
    } alu_fn_e;

    alu_fn_e          fn;
    logic             ena;
    logic             enb;
    logic             inva;
    logic             inc;
    logic [NBITS-1:0] ea;
    logic [NBITS-1:0] eb;
    logic [NBITS-1:0] xa;
    logic             n_d;
    logic             z_d;

    assign fn   = alu_fn_e'(ctrl[5:4]);
    assign ena  = ctrl[3];
    assign enb  = ctrl[2];
    assign inva = ctrl[1];
    assign inc  = ctrl[0];

    assign ea = ena  ? a   : '0;
    assign eb = enb  ? b   : '0;
    assign xa = inva ? ~ea : ea;

    // NOTE: assign a default before the case so every path drives y and no
    // latch is inferred, even if the case is later edited.
    always_comb begin
        y = '0;
        unique case (fn)
            FN_AND:  y = xa & eb;
            FN_OR:   y = xa | eb;
            FN_NOTB: y = ~eb;
            // Carry-out falls off the top; INC only matters in this mode.
            FN_ADD:  y = xa + eb + NBITS'(inc);
            default: y = '0;
        endcase
    end

    assign n = y[NBITS-1];
    assign z = (y == '0);

    assign n_d = n;
    assign z_d = z;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input at the same edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            n_q <= n_d;
            z_q <= z_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: table of hand-computed vectors for the
// combinational path, then hand-written sequences for flag registers and reset.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  ctrl;
    logic [31:0] y;
    logic        n;
    logic        z;
    logic        n_q;
    logic        z_q;

    int n_cmp = 0;
    int n_bad = 0;

    alu #(.NBITS(32), .ALU_CONTROL(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .ctrl (ctrl),
        .y    (y),
        .n    (n),
        .z    (z),
        .n_q  (n_q),
        .z_q  (z_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] c, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        ctrl = c;
        a    = va;
        b    = vb;
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        a     = 32'h0;
        b     = 32'h0;
        ctrl  = 6'h10;

        // Named operations on the reference operands.
        vecs.push_back('{"A",      6'h18, 32'h0000CDCD, 32'h0000ABAB, 32'h0000CDCD});
        vecs.push_back('{"B",      6'h14, 32'h0000CDCD, 32'h0000ABAB, 32'h0000ABAB});
        vecs.push_back('{"~A",     6'h1A, 32'h0000CDCD, 32'h0000ABAB, 32'hFFFF3232});
        vecs.push_back('{"~B",     6'h2C, 32'h0000CDCD, 32'h0000ABAB, 32'hFFFF5454});
        vecs.push_back('{"A+B",    6'h3C, 32'h0000CDCD, 32'h0000ABAB, 32'h00017978});
        vecs.push_back('{"A+B+1",  6'h3D, 32'h0000CDCD, 32'h0000ABAB, 32'h00017979});
        vecs.push_back('{"A+1",    6'h39, 32'h0000CDCD, 32'h0000ABAB, 32'h0000CDCE});
        vecs.push_back('{"B+1",    6'h35, 32'h0000CDCD, 32'h0000ABAB, 32'h0000ABAC});
        vecs.push_back('{"B-A",    6'h3F, 32'h0000CDCD, 32'h0000ABAB, 32'hFFFFDDDE});
        vecs.push_back('{"B-1",    6'h36, 32'h0000CDCD, 32'h0000ABAB, 32'h0000ABAA});
        vecs.push_back('{"-A",     6'h3B, 32'h0000CDCD, 32'h0000ABAB, 32'hFFFF3233});
        vecs.push_back('{"A&B",    6'h0C, 32'h0000CDCD, 32'h0000ABAB, 32'h00008989});
        vecs.push_back('{"A|B",    6'h1C, 32'h0000CDCD, 32'h0000ABAB, 32'h0000EFEF});
        vecs.push_back('{"ZERO",   6'h10, 32'h0000CDCD, 32'h0000ABAB, 32'h00000000});
        vecs.push_back('{"ONE",    6'h31, 32'h0000CDCD, 32'h0000ABAB, 32'h00000001});
        vecs.push_back('{"NEG1",   6'h32, 32'h0000CDCD, 32'h0000ABAB, 32'hFFFFFFFF});
        // Sign bit, wrap-around, INC ignored outside the adder, other operands.
        vecs.push_back('{"A_msb",  6'h18, 32'h80000000, 32'h00000000, 32'h80000000});
        vecs.push_back('{"wrap",   6'h3C, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
        vecs.push_back('{"or_inc", 6'h19, 32'h0000CDCD, 32'h0000ABAB, 32'h0000CDCD});
        vecs.push_back('{"and_inc",6'h0D, 32'h0000CDCD, 32'h0000ABAB, 32'h00008989});
        vecs.push_back('{"nb_inc", 6'h2D, 32'h0000CDCD, 32'h0000ABAB, 32'hFFFF5454});
        vecs.push_back('{"add2",   6'h3C, 32'h12345678, 32'h0F0F0F0F, 32'h21436587});
        vecs.push_back('{"b_a_m1", 6'h3E, 32'h00000005, 32'h00000003, 32'hFFFFFFFD});
        vecs.push_back('{"nota_b", 6'h0E, 32'hF0F0FFFF, 32'hFFFF0000, 32'h0F0F0000});

        // Asynchronous reset at a non-edge time; flags must read zero.
        #3 rst_n = 1'b0;
        #1;
        check("reset_n_q", {31'b0, n_q}, 32'h0);
        check("reset_z_q", {31'b0, z_q}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_y"}, y, vecs[i].y);
            check({vecs[i].name, "_n"}, {31'b0, n}, {31'b0, vecs[i].y[31]});
            check({vecs[i].name, "_z"}, {31'b0, z}, {31'b0, (vecs[i].y == 32'h0)});
        end

        // Registered flags follow the previous cycle's status.
        drive(6'h10, 32'h0000CDCD, 32'h0000ABAB);
        @(posedge clk); #1;
        check("reg_zero_z_q", {31'b0, z_q}, 32'h1);
        check("reg_zero_n_q", {31'b0, n_q}, 32'h0);
        drive(6'h32, 32'h0000CDCD, 32'h0000ABAB);
        check("reg_hold_z_q", {31'b0, z_q}, 32'h1);
        @(posedge clk); #1;
        check("reg_neg_n_q", {31'b0, n_q}, 32'h1);
        check("reg_neg_z_q", {31'b0, z_q}, 32'h0);

        // Mid-cycle reset clears flags at once and holds them across edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_n_q", {31'b0, n_q}, 32'h0);
        check("midrst_z_q", {31'b0, z_q}, 32'h0);
        check("midrst_y",   y, 32'hFFFFFFFF);
        check("midrst_n",   {31'b0, n}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("rsthold_n_q", {31'b0, n_q}, 32'h0);
        check("rsthold_z_q", {31'b0, z_q}, 32'h0);

        // Release with a zero result: next edge captures z.
        @(negedge clk);
        ctrl  = 6'h10;
        rst_n = 1'b1;
        #1;
        check("rel_pre_z_q", {31'b0, z_q}, 32'h0);
        @(posedge clk); #1;
        check("rel_z_q", {31'b0, z_q}, 32'h1);
        check("rel_n_q", {31'b0, n_q}, 32'h0);

        // Wrap-around result latched as zero.
        drive(6'h3C, 32'hFFFFFFFF, 32'h00000001);
        @(posedge clk); #1;
        check("wrap_z_q", {31'b0, z_q}, 32'h1);
        check("wrap_n_q", {31'b0, n_q}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
